regfile: RTL and testbench
==========================

// Module: regfile
// PURPOSE
//  Architectural register file with rename tags, sitting between decoder, ROB and issue path.
//  - Takes ROB commits and writes x1..x31.
//  - At issue, records which ROB entry will produce each rd.
//  - Answers the decoder's rs1/rs2 lookups in the same cycle with {has_dep, rob_id, value}.
//    The ROB consumes this triple (search_in_*), resolves pending deps and registers the result.
// PARAMETERS
//  ROB_WIDTH  4   bits of a ROB entry id (ROB holds 2**ROB_WIDTH entries)
//  NREG       32  architectural registers; x0 hardwired to zero
// PORTS
//  clk_in               in   1          system clock, all state updates on posedge
//  rst_in               in   1          reset, asynchronous, active-low
//  rdy_in               in   1          global ready; when low all state holds
//  clear                in   1          ROB mispredict flush; drops all rename tags
//  dec_ready            in   1          decoder issues one instruction this cycle
//  issue_rd             in   5          destination reg of issued instr (0 = none)
//  issue_rob_id         in   ROB_WIDTH  ROB entry allocated to the issued instr
//  rs1                  in   5          source reg 1 lookup address
//  rs2                  in   5          source reg 2 lookup address
//  commit_ready         in   1          ROB commits a register write this cycle
//  commit_rob_id        in   ROB_WIDTH  ROB entry being committed
//  commit_reg_id        in   5          destination reg of commit
//  commit_val           in   32         value to write
//  search_in_has_dep_1  out  1          rs1 still awaits an uncommitted producer
//  search_rob_id_1      out  ROB_WIDTH  producer ROB id for rs1 (0 when no dep)
//  search_in_val_1      out  32         committed value of rs1 (0 when dep)
//  search_in_has_dep_2  out  1          as above for rs2
//  search_rob_id_2      out  ROB_WIDTH  as above for rs2
//  search_in_val_2      out  32         as above for rs2
// BEHAVIOUR
//  - State per reg: val[31:0], busy, tag[ROB_WIDTH-1:0]. x0: val=0, busy=0, never written.
//  - Reset (rst_in low, async): all val=0, busy=0, tag=0; outputs then read has_dep=0, id=0, val=0.
//  - rdy_in low: no state change; lookup outputs remain combinational on current state.
//  - Lookup is combinational, zero latency, and reflects state BEFORE this cycle's issue.
//    An instr with rs==rd therefore sees the previous producer, not itself.
//  - Commit forwarding in lookup: if commit_ready && commit_reg_id==rs && rs!=0
//    && busy[rs] && tag[rs]==commit_rob_id, output has_dep=0, id=0, val=commit_val.
//    Required because the ROB frees the entry one cycle before this commit arrives.
//  - Otherwise: busy[rs] ? {1, tag[rs], 0} : {0, 0, val[rs]}.
//  - Posedge with rdy_in high, applied in order:
//    1 Commit (commit_ready, reg!=0):
//      - val[reg] <= commit_val.
//      - busy[reg] <= 0 only if tag[reg]==commit_rob_id (a younger producer keeps ownership).
//    2 Issue (dec_ready, issue_rd!=0, !clear): busy[rd] <= 1, tag[rd] <= issue_rob_id.
//      Overrides the step-1 busy clear when both hit the same reg.
//    3 Clear: every busy <= 0 and issue is ignored; the step-1 value write still lands.
//  - No internal FSM beyond per-reg busy; no backpressure, one issue and one commit per cycle.
//  - Widths: tags compare full ROB_WIDTH; wrap-around of ROB ids is handled entirely by the ROB.
//    The regfile only does equality on ids.
// TESTING
//  1 Reset low mid-run: while asserted, all lookups return has_dep=0, val=0.
//    After release, a commit x5=0x1234 makes rs1=5 read val 0x1234.
//  2 Issue rd=3 id=2, next cycle rs1=3 -> has_dep=1, id=2.
//    Commit x3 id=2 val=7 -> same-cycle lookup 0/0/7, then busy cleared.
//  3 Issue rd=4 id=1, then rd=4 id=6.
//    Commit x4 id=1 val=9 -> val[4]=9, lookup still has_dep=1 id=6.
//  4 Same cycle: issue rd=8 id=3 and commit x8 (matching old tag) val=5.
//    Next cycle: has_dep=1 id=3; the regfile's stored val[8]=5.
//  5 Issue rd=0 and commit x0 val=0xFFFF -> rs1=0 always reads 0, has_dep=0.
//  6 Issue x1,x2, then clear with concurrent issue rd=9.
//    Next cycle: x1, x2, x9 all has_dep=0 and hold their old values.
//    rdy_in low for 3 cycles during an issue: no change.

Source files
------------

// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
// Module   : regfile
// Brief    : Architectural register file with per-register rename tags and
//            same-cycle rs1/rs2 lookup with commit forwarding.
// Revision : 1.0
// ============================================================================
module regfile #(
    parameter int ROB_WIDTH = 4,
    parameter int NREG      = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear,
    input  logic                 dec_ready,
    input  logic [4:0]           issue_rd,
    input  logic [ROB_WIDTH-1:0] issue_rob_id,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic                 commit_ready,
    input  logic [ROB_WIDTH-1:0] commit_rob_id,
    input  logic [4:0]           commit_reg_id,
    input  logic [31:0]          commit_val,
    output logic                 search_in_has_dep_1,
    output logic [ROB_WIDTH-1:0] search_rob_id_1,
    output logic [31:0]          search_in_val_1,
    output logic                 search_in_has_dep_2,
    output logic [ROB_WIDTH-1:0] search_rob_id_2,
    output logic [31:0]          search_in_val_2
);

    typedef struct packed {
        logic                 dep;
        logic [ROB_WIDTH-1:0] id;
        logic [31:0]          val;
    } lookup_t;

    logic [31:0]          val_q  [NREG];
    logic                 busy_q [NREG];
    logic [ROB_WIDTH-1:0] tag_q  [NREG];
    logic [31:0]          val_d  [NREG];
    logic                 busy_d [NREG];
    logic [ROB_WIDTH-1:0] tag_d  [NREG];

    // Forwarding covers the cycle where the ROB has already released the entry
    // but the value has not yet reached val_q.
    function automatic lookup_t lookup(input logic [4:0] rs);
        lookup_t r;
        r = '0;
        if (commit_ready && (commit_reg_id == rs) && (rs != 5'd0) &&
            busy_q[rs] && (tag_q[rs] == commit_rob_id)) begin
            r.val = commit_val;
        end else if (busy_q[rs]) begin
            r.dep = 1'b1;
            r.id  = tag_q[rs];
        end else begin
            r.val = val_q[rs];
        end
        return r;
    endfunction

    lookup_t w_lk1;
    lookup_t w_lk2;

    always_comb begin
        w_lk1 = lookup(rs1);
        w_lk2 = lookup(rs2);
    end

    assign search_in_has_dep_1 = w_lk1.dep;
    assign search_rob_id_1     = w_lk1.id;
    assign search_in_val_1     = w_lk1.val;
    assign search_in_has_dep_2 = w_lk2.dep;
    assign search_rob_id_2     = w_lk2.id;
    assign search_in_val_2     = w_lk2.val;

    // Commit, then issue (wins on busy), then clear (wins over everything busy).
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            val_d[i]  = val_q[i];
            busy_d[i] = busy_q[i];
            tag_d[i]  = tag_q[i];
        end
        if (commit_ready && (commit_reg_id != 5'd0)) begin
            val_d[commit_reg_id] = commit_val;
            if (tag_q[commit_reg_id] == commit_rob_id) begin
                busy_d[commit_reg_id] = 1'b0;
            end
        end
        if (dec_ready && (issue_rd != 5'd0) && !clear) begin
            busy_d[issue_rd] = 1'b1;
            tag_d[issue_rd]  = issue_rob_id;
        end
        if (clear) begin
            for (int i = 0; i < NREG; i++) begin
                busy_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NREG; i++) begin
                val_q[i]  <= '0;
                busy_q[i] <= 1'b0;
                tag_q[i]  <= '0;
            end
        end else if (rdy_in) begin
            for (int i = 0; i < NREG; i++) begin
                val_q[i]  <= val_d[i];
                busy_q[i] <= busy_d[i];
                tag_q[i]  <= tag_d[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile
// Brief    : Directed vector-table bench for regfile.
// Revision : 1.0
// ============================================================================
module tb_regfile;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        clear = 1'b0;
    logic        dec_ready = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic [3:0]  issue_rob_id = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic        commit_ready = 1'b0;
    logic [3:0]  commit_rob_id = '0;
    logic [4:0]  commit_reg_id = '0;
    logic [31:0] commit_val = '0;
    logic        d1, d2;
    logic [3:0]  i1, i2;
    logic [31:0] v1, v2;

    int n_cmp = 0;
    int n_bad = 0;

    regfile #(.ROB_WIDTH(4), .NREG(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .dec_ready(dec_ready), .issue_rd(issue_rd), .issue_rob_id(issue_rob_id),
        .rs1(rs1), .rs2(rs2), .commit_ready(commit_ready),
        .commit_rob_id(commit_rob_id), .commit_reg_id(commit_reg_id),
        .commit_val(commit_val),
        .search_in_has_dep_1(d1), .search_rob_id_1(i1), .search_in_val_1(v1),
        .search_in_has_dep_2(d2), .search_rob_id_2(i2), .search_in_val_2(v2)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        rdy, clr, dec;
        logic [4:0]  ird;
        logic [3:0]  iid;
        logic        cr;
        logic [3:0]  cid;
        logic [4:0]  creg;
        logic [31:0] cval;
        logic [4:0]  r1, r2;
        logic [36:0] e1, e2;  // {has_dep, rob_id, val}
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    function automatic vec_t mk(logic rdy, logic clr, logic dec, logic [4:0] ird,
                                logic [3:0] iid, logic cr, logic [3:0] cid,
                                logic [4:0] creg, logic [31:0] cval,
                                logic [4:0] r1, logic [36:0] e1,
                                logic [4:0] r2, logic [36:0] e2);
        vec_t v;
        v.rdy = rdy; v.clr = clr; v.dec = dec; v.ird = ird; v.iid = iid;
        v.cr = cr; v.cid = cid; v.creg = creg; v.cval = cval;
        v.r1 = r1; v.e1 = e1; v.r2 = r2; v.e2 = e2;
        return v;
    endfunction

    function automatic logic [36:0] L(logic d, logic [3:0] id, logic [31:0] val);
        return {d, id, val};
    endfunction

    task automatic chk(input string nm, input logic [36:0] act, input logic [36:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got dep=%0b id=%0d val=%h, expected dep=%0b id=%0d val=%h",
                     nm, act[36], act[35:32], act[31:0], exp[36], exp[35:32], exp[31:0]);
        end
    endtask

    task automatic idle();
        rdy_in = 1'b1; clear = 1'b0; dec_ready = 1'b0; issue_rd = '0; issue_rob_id = '0;
        commit_ready = 1'b0; commit_rob_id = '0; commit_reg_id = '0; commit_val = '0;
    endtask

    initial begin
        logic [36:0] z;
        z = L(1'b0, 4'd0, 32'd0);
        //               rdy clr dec ird iid  cr cid creg cval        r1 exp1                  r2 exp2
        vecs[0]  = mk(1, 0, 1, 3, 2,   0, 0, 0, 0,            3, z,                    0, z);
        vecs[1]  = mk(1, 0, 0, 0, 0,   0, 0, 0, 0,            3, L(1, 2, 0),           5, z);
        vecs[2]  = mk(1, 0, 0, 0, 0,   1, 2, 3, 32'd7,        3, L(0, 0, 7),           3, L(0, 0, 7));
        vecs[3]  = mk(1, 0, 0, 0, 0,   0, 0, 0, 0,            3, L(0, 0, 7),           0, z);
        vecs[4]  = mk(1, 0, 1, 4, 1,   0, 0, 0, 0,            4, z,                    3, L(0, 0, 7));
        vecs[5]  = mk(1, 0, 1, 4, 6,   0, 0, 0, 0,            4, L(1, 1, 0),           0, z);
        vecs[6]  = mk(1, 0, 0, 0, 0,   1, 1, 4, 32'd9,        4, L(1, 6, 0),           3, L(0, 0, 7));
        vecs[7]  = mk(1, 0, 0, 0, 0,   0, 0, 0, 0,            4, L(1, 6, 0),           0, z);
        vecs[8]  = mk(1, 0, 0, 0, 0,   1, 6, 4, 32'h44,       4, L(0, 0, 32'h44),      0, z);
        vecs[9]  = mk(1, 0, 0, 0, 0,   0, 0, 0, 0,            4, L(0, 0, 32'h44),      0, z);
        vecs[10] = mk(1, 0, 1, 8, 7,   0, 0, 0, 0,            8, z,                    0, z);
        vecs[11] = mk(1, 0, 1, 8, 3,   1, 7, 8, 32'd5,        8, L(0, 0, 5),           0, z);
        vecs[12] = mk(1, 0, 0, 0, 0,   0, 0, 0, 0,            8, L(1, 3, 0),           0, z);
        vecs[13] = mk(1, 1, 0, 0, 0,   0, 0, 0, 0,            8, L(1, 3, 0),           0, z);
        vecs[14] = mk(1, 0, 0, 0, 0,   0, 0, 0, 0,            8, L(0, 0, 5),           0, z);
        vecs[15] = mk(1, 0, 1, 0, 5,   1, 0, 0, 32'hFFFF,     0, z,                    0, z);
        vecs[16] = mk(1, 0, 0, 0, 0,   0, 0, 0, 0,            0, z,                    0, z);
        vecs[17] = mk(1, 0, 1, 1, 8,   0, 0, 0, 0,            1, z,                    0, z);
        vecs[18] = mk(1, 0, 1, 2, 9,   0, 0, 0, 0,            1, L(1, 8, 0),           0, z);
        vecs[19] = mk(1, 1, 1, 9, 10,  1, 3, 1, 32'h11,       2, L(1, 9, 0),           1, L(1, 8, 0));
        vecs[20] = mk(1, 0, 0, 0, 0,   0, 0, 0, 0,            1, L(0, 0, 32'h11),      9, z);
        vecs[21] = mk(1, 0, 0, 0, 0,   0, 0, 0, 0,            2, z,                    5, z);
        vecs[22] = mk(0, 0, 1, 6, 4,   1, 0, 7, 32'h77,       6, z,                    7, z);
        vecs[23] = mk(0, 0, 1, 6, 4,   1, 0, 7, 32'h77,       6, z,                    7, z);
        vecs[24] = mk(0, 0, 1, 6, 4,   1, 0, 7, 32'h77,       6, z,                    7, z);
        vecs[25] = mk(1, 0, 0, 0, 0,   0, 0, 0, 0,            6, z,                    7, z);

        idle();
        repeat (2) @(negedge clk_in);
        #1 chk("reset_rs1", {d1, i1, v1}, z);
        @(negedge clk_in);
        rst_in = 1'b1;

        for (int k = 0; k < NV; k++) begin
            @(negedge clk_in);
            rdy_in = vecs[k].rdy; clear = vecs[k].clr; dec_ready = vecs[k].dec;
            issue_rd = vecs[k].ird; issue_rob_id = vecs[k].iid;
            commit_ready = vecs[k].cr; commit_rob_id = vecs[k].cid;
            commit_reg_id = vecs[k].creg; commit_val = vecs[k].cval;
            rs1 = vecs[k].r1; rs2 = vecs[k].r2;
            #2;
            chk($sformatf("vec%0d_rs1", k), {d1, i1, v1}, vecs[k].e1);
            chk($sformatf("vec%0d_rs2", k), {d2, i2, v2}, vecs[k].e2);
        end

        // Mid-run asynchronous reset wipes both busy tags and values.
        @(negedge clk_in);
        idle();
        dec_ready = 1'b1; issue_rd = 5'd10; issue_rob_id = 4'd11;
        commit_ready = 1'b1; commit_reg_id = 5'd12; commit_val = 32'hABC;
        @(negedge clk_in);
        idle(); rs1 = 5'd10; rs2 = 5'd12;
        #1 chk("pre_rst_rs1", {d1, i1, v1}, L(1, 11, 0));
        chk("pre_rst_rs2", {d2, i2, v2}, L(0, 0, 32'hABC));
        #1 rst_in = 1'b0;
        #1 chk("in_rst_rs1", {d1, i1, v1}, z);
        chk("in_rst_rs2", {d2, i2, v2}, z);
        dec_ready = 1'b1; issue_rd = 5'd10; issue_rob_id = 4'd3;
        @(negedge clk_in);
        #1 chk("hold_rst_rs1", {d1, i1, v1}, z);
        @(negedge clk_in);
        rst_in = 1'b1;
        idle(); rs1 = 5'd5; rs2 = 5'd12;
        commit_ready = 1'b1; commit_reg_id = 5'd5; commit_rob_id = 4'd0; commit_val = 32'h1234;
        #1 chk("post_rst_pre_commit", {d1, i1, v1}, z);
        @(negedge clk_in);
        idle();
        #1 chk("post_rst_x5", {d1, i1, v1}, L(0, 0, 32'h1234));
        chk("post_rst_x12", {d2, i2, v2}, z);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
